// File: rtl/md_iter_unit.sv
// rtl/md_iter_unit.sv - iterative shift-add multiply / restoring divide sequencer owning HI/LO
// Optional MD_EARLY_TERM_EN: MULT leaves RUN once the remaining multiplier bits are all zero.
module md_iter_unit #(
  parameter int               XLEN    = 32,
  parameter logic [XLEN-1:0]  DIV0_LO = {XLEN{1'b1}}
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      func,
  input  logic            sign,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  input  logic            rd_req,
  input  logic            cancel,
  output logic            busy,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  localparam logic [2:0] F_MULT = 3'b001;
  localparam logic [2:0] F_DIV  = 3'b010;
  localparam logic [2:0] F_MTHI = 3'b011;
  localparam logic [2:0] F_MTLO = 3'b100;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     count;
  logic              is_div, sa, sb;
  logic [XLEN-1:0]   opa_raw;
  logic [XLEN-1:0]   opb_mag;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] mcand;

  logic              accept;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [2*XLEN-1:0] acc_mul, acc_div;
  logic [XLEN-1:0]   mplier_nx;
  logic [XLEN:0]     shifted_rem, diff;
  logic              ge, last;
  logic [2*XLEN-1:0] mul_res;
  logic [XLEN-1:0]   quo, rem, quo_res, rem_res;

  assign busy      = (state != IDLE);
  assign stall_req = busy & (rd_req | start);

  assign accept = (state == IDLE) & start & ~cancel & ((func == F_MULT) | (func == F_DIV));
  assign a_mag  = (sign & opa[XLEN-1]) ? -opa : opa;
  assign b_mag  = (sign & opb[XLEN-1]) ? -opb : opb;

  // Multiply: accumulate the left-shifting multiplicand while the multiplier shifts right.
  assign acc_mul   = acc + (opb_mag[0] ? mcand : '0);
  assign mplier_nx = opb_mag >> 1;

  // Divide: acc holds {partial remainder, dividend/quotient}; shifted remainder needs one extra bit.
  assign shifted_rem = acc[2*XLEN-1:XLEN-1];
  assign ge          = (shifted_rem >= {1'b0, opb_mag});
  assign diff        = shifted_rem - {1'b0, opb_mag};
  assign acc_div     = ge ? {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1} : {acc[2*XLEN-2:0], 1'b0};

`ifdef MD_EARLY_TERM_EN
  assign last = (count == LAST) | (~is_div & (mplier_nx == '0));
`else
  assign last = (count == LAST);
`endif

  assign mul_res = (sa ^ sb) ? -acc : acc;
  assign quo     = acc[XLEN-1:0];
  assign rem     = acc[2*XLEN-1:XLEN];
  assign quo_res = (sa ^ sb) ? -quo : quo;
  assign rem_res = sa ? -rem : rem;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (cancel) state_nx = IDLE;
               else if (last) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      is_div  <= 1'b0;
      sa      <= 1'b0;
      sb      <= 1'b0;
      opa_raw <= '0;
      opb_mag <= '0;
      acc     <= '0;
      mcand   <= '0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            count   <= '0;
            is_div  <= (func == F_DIV);
            sa      <= sign & opa[XLEN-1];
            sb      <= sign & opb[XLEN-1];
            opa_raw <= opa;
            opb_mag <= b_mag;
            acc     <= (func == F_DIV) ? {{XLEN{1'b0}}, a_mag} : '0;
            mcand   <= {{XLEN{1'b0}}, a_mag};
          end else if (start && !cancel && func == F_MTHI) begin
            hi <= opa;
          end else if (start && !cancel && func == F_MTLO) begin
            lo <= opa;
          end
        end
        RUN: begin
          count <= count + 1'b1;
          if (is_div) begin
            acc <= acc_div;
          end else begin
            acc     <= acc_mul;
            mcand   <= mcand << 1;
            opb_mag <= mplier_nx;
          end
        end
        FIX: begin
          if (!cancel) begin
            done <= 1'b1;
            if (!is_div) begin
              {hi, lo} <= mul_res;
            end else if (opb_mag == '0) begin
              hi <= opa_raw;
              lo <= DIV0_LO;
            end else begin
              hi <= rem_res;
              lo <= quo_res;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md_iter_unit.sv
// tb/tb_md_iter_unit.sv - scoreboard bench for md_iter_unit against a plain-arithmetic reference model
module tb_md_iter_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  func = 3'd0;
  logic        sign = 1'b0;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic        rd_req = 1'b0;
  logic        cancel = 1'b0;
  logic        busy, stall_req, done;
  logic [31:0] hi, lo;

  int compared = 0;
  int mismatched = 0;
  logic [63:0] exp_q[$];
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  md_iter_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .func(func), .sign(sign),
    .opa(opa), .opb(opb), .rd_req(rd_req), .cancel(cancel),
    .busy(busy), .stall_req(stall_req), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic [2:0] f, input logic s,
                                             input logic [31:0] a, input logic [31:0] b);
    longint x, y, p, q, r;
    logic [63:0] u;
    if (f == 3'd1) begin
      if (s) begin
        x = longint'($signed(a));
        y = longint'($signed(b));
        p = x * y;
        return p;
      end
      u = {32'd0, a} * {32'd0, b};
      return u;
    end
    if (b == 0) return {a, 32'hFFFFFFFF};
    if (s) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
      q = x / y;
      r = x % y;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  function automatic int ref_busy(input logic [2:0] f, input logic s, input logic [31:0] b);
`ifdef MD_EARLY_TERM_EN
    logic [31:0] m;
    int runs;
    if (f == 3'd1) begin
      m = (s && b[31]) ? -b : b;
      runs = 1;
      for (int i = 0; i < 32; i++) if (m[i]) runs = i + 1;
      return runs + 1;
    end
`endif
    return 33;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", {hi, lo}, 64'hx);
      end else begin
        chk("result_hilo", {hi, lo}, exp_q.pop_front());
      end
    end
  end

  // mode 0: run to completion, 1: cancel at RUN cycle 10, 2: reset at cycle 5
  task automatic do_op(input logic [2:0] f, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input int mode);
    int n;
    bit aborted;
    logic [63:0] e;
    start = 1'b1; func = f; sign = s; opa = a; opb = b;
    @(posedge clk); #1;
    start = 1'b0; func = 3'd0;
    if (f == 3'd1 || f == 3'd2) begin
      if (mode == 0) begin
        e = ref_result(f, s, a, b);
        exp_q.push_back(e);
        model_hi = e[63:32];
        model_lo = e[31:0];
      end
      n = 0;
      aborted = 0;
      @(negedge clk);
      while (busy && n < 200) begin
        n++;
        if (mode == 1 && n == 10) begin
          cancel = 1'b1;
          @(posedge clk); #1;
          cancel = 1'b0;
          chk("cancel_busy", {63'd0, busy}, 64'd0);
          chk("cancel_hilo", {hi, lo}, {model_hi, model_lo});
          aborted = 1;
          break;
        end
        if (mode == 2 && n == 5) begin
          #1 rst_n = 1'b0;
          #1;
          chk("rst_busy_done", {62'd0, busy, done}, 64'd0);
          chk("rst_hilo", {hi, lo}, 64'd0);
          model_hi = '0;
          model_lo = '0;
          @(negedge clk) rst_n = 1'b1;
          aborted = 1;
          break;
        end
        rd_req = 1'($urandom_range(0, 1));
        start  = ($urandom_range(0, 3) == 0);
        func   = 3'd3;
        opa    = $urandom;
        #1;
        chk("stall_req", {63'd0, stall_req}, {63'd0, rd_req | start});
        @(negedge clk);
      end
      start = 1'b0; rd_req = 1'b0; func = 3'd0;
      if (!aborted) begin
        chk("busy_cycles", 64'(n), 64'(ref_busy(f, s, b)));
        chk("done_rise", {63'd0, done}, 64'd1);
        @(negedge clk);
        chk("done_width", {63'd0, done}, 64'd0);
      end else begin
        @(negedge clk);
        chk("no_done", {63'd0, done}, 64'd0);
      end
    end else begin
      if (f == 3'd3) model_hi = a;
      if (f == 3'd4) model_lo = a;
      chk("mt_busy", {63'd0, busy}, 64'd0);
      chk("mt_hilo", {hi, lo}, {model_hi, model_lo});
    end
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] f;
    #1;
    chk("reset_outputs", {61'd0, busy, done, stall_req}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(3'd1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    do_op(3'd2, 1'b1, 32'hFFFFFFF9, 32'd2, 0);
    do_op(3'd2, 1'b1, 32'h80000000, 32'hFFFFFFFF, 0);
    do_op(3'd2, 1'b0, 32'd5, 32'd0, 0);
    do_op(3'd2, 1'b1, 32'hFFFFFFFB, 32'd0, 0);
    do_op(3'd3, 1'b0, 32'h1234, 32'd0, 0);
    do_op(3'd4, 1'b0, 32'h5678, 32'd0, 0);
    do_op(3'd1, 1'b0, 32'd3, 32'd5, 0);
    do_op(3'd1, 1'b1, 32'hFFFFFFFD, 32'd7, 0);
    do_op(3'd1, 1'b0, 32'h00ABCDEF, 32'h13572468, 1);

    // Cancel together with start in IDLE drops the command.
    start = 1'b1; func = 3'd3; opa = 32'hDEADBEEF; cancel = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0; func = 3'd0;
    chk("cancel_idle_mthi", {hi, lo}, {model_hi, model_lo});
    @(negedge clk);

    do_op(3'd2, 1'b0, 32'd1000, 32'd7, 2);
    do_op(3'd1, 1'b0, 32'd6, 32'd7, 0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: f = 3'd1;
        3, 4, 5: f = 3'd2;
        6:       f = 3'd3;
        7:       f = 3'd4;
        default: f = 3'($urandom_range(5, 7));
      endcase
      do_op(f, 1'($urandom_range(0, 1)), pick_val(), pick_val(),
            ($urandom_range(0, 9) == 0) ? 1 : 0);
    end

    @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
